clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock divider and tick generator. Each of N_CH channels divides `clk` by a runtime-loadable ratio and drives a 50%-duty divided clock plus a one-cycle tick strobe. Ratio changes are taken through a valid/ready handshake and applied glitch-free at the channel's next terminal count. The block sits at the top level and feeds slow clocks and enables to display, debounce and stepping logic.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- N_CH, 4: number of channels (1..16).
- CNT_W, 32: counter and divisor width.
- DEFAULT_DIV, 10000000: divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write accepted when high with cfg_valid.
- cfg_ch  in  CH_W  target channel, CH_W = max(1, clog2(N_CH)).
- cfg_div  in  CNT_W  new divisor.
- en  in  N_CH  per-channel run enable.
- sync  in  1  global restart (present only with CLK_DIV_SYNC_EN).
- dclk  out  N_CH  divided clocks, period 2*div cycles.
- tick  out  N_CH  one-cycle strobe at each dclk toggle.

## Operation
- Per channel: registers cnt, div, pending_div, pending flag, dclk, tick.
- Reset: cnt=0, div=DEFAULT_DIV, pending=0, dclk=0, tick=0; cfg_ready=1.
- Running (en[i]=1): each edge cnt increments; at the edge where cnt==div-1: cnt<=0, dclk<=~dclk, tick<=1; otherwise tick<=0.
- Stopped (en[i]=0): cnt and dclk hold, tick<=0. Re-enable resumes from held cnt.
- Divisor 0 is stored as 1. div=1: dclk toggles every edge, tick stays high while enabled.
- Handshake: cfg_ready = !pending[cfg_ch] (combinational on cfg_ch). Accept = cfg_valid && cfg_ready: pending_div<=cfg_div, pending<=1.
- cfg_ch >= N_CH: cfg_ready=1, write accepted and discarded.
- Apply: if pending and (terminal count edge, or en[i]=0): div<=pending_div, cnt<=0, pending<=0. Terminal-count actions (toggle, tick) still occur on that edge.
- Accept and terminal count on the same edge: the new value becomes pending and applies at the following terminal count, never on the same edge.
- Asynchronous reset mid-period or mid-handshake: all state returns to reset values; pending writes are lost.

## Timing
- en held high from reset release: first dclk rise and tick at the DEFAULT_DIV-th edge; dclk period 2*div edges.
- tick and dclk are registered; no combinational path from inputs to them.
- cfg_ready is combinational from cfg_ch and internal state only.
- Ratio change with en high: takes effect at most div_old edges after accept; the next half-period is exactly div_new edges.
- Ratio change with en low: applied on the edge after accept; cfg_ready for that channel low for exactly one cycle.

## Configuration
- CLK_DIV_SYNC_EN defined: `sync` port present; sync=1 at an edge forces every channel cnt<=0, dclk<=0, tick<=0 and applies any pending divisor; sync overrides terminal count on the same edge.
- Not defined: `sync` port absent; channels free-run independently; no other behaviour changes.

## Structure
- Package clk_div_pkg: DEFAULT_DIV default, CNT_W default, CH_W computation function.
- Sub-module clk_div_channel: one channel (counter, divisor, pending register, dclk/tick); the bank instantiates N_CH copies via generate and does cfg_ch decode and cfg_ready mux.

## Test plan
- Reset, en=4'b0001, DEFAULT_DIV=4 -> dclk[0] rises at edge 4, falls at 8; tick[0] high cycles after edges 4, 8; other channels idle at 0.
- Write ch1 div=3 while en[1]=0 -> cfg_ready low one cycle; enable -> dclk[1] period 6 edges.
- Ch0 running div=4, write div=2 at cnt=1 -> old half-period completes (toggle at cnt 3), following half-periods 2 edges; second write before apply stalls with cfg_ready=0.
- Write div=0 and cfg_ch=7 (N_CH=4) -> div stored as 1, dclk toggles every edge; out-of-range write accepted, no channel changes.
- Assert rst mid-period with pending write -> all dclk/tick 0 immediately, div back to DEFAULT_DIV, pending cleared.
- With CLK_DIV_SYNC_EN, channels div 3 and 5 running, pulse sync -> both cnt=0, dclk=0 next edge, then toggle at edges 3 and 5 after sync.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clk_div_bank clock divider bank.
package clk_div_pkg;

  // Counter/divisor width used when the bank is instantiated without overrides.
  localparam int CNT_W_DEF       = 32;
  // Divisor loaded into every channel at reset (slow default tick).
  localparam int DEFAULT_DIV_DEF = 10000000;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter, active divisor, one-deep pending
// divisor slot, registered divided clock and tick strobe.
// A new divisor is only ever swapped in at a terminal count, while stopped, or
// on a global restart, so the divided clock never produces a runt half-period.
module clk_div_channel #(
  parameter int CNT_W   = 32,
  parameter int RST_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             dclk_o,
  output logic             tick_o
);

  // A zero reset divisor would never reach terminal count; treat it as 1.
  localparam logic [CNT_W-1:0] RST_DIV_V =
    (RST_DIV == 0) ? CNT_W'(1) : CNT_W'(RST_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;
  logic             tc;

  // Terminal count: last edge of the current half-period.
  assign tc = (cnt_q == (div_q - CNT_W'(1)));

  // Next-state: restart, run, stop/apply, then capture of an accepted write.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    dclk_d = dclk_q;
    tick_d = 1'b0;

    if (sync_i) begin
      // Global restart wins over terminal count and re-phases every channel.
      cnt_d  = '0;
      dclk_d = 1'b0;
      if (pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else if (en_i) begin
      if (tc) begin
        cnt_d  = '0;
        dclk_d = ~dclk_q;
        tick_d = 1'b1;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pend_q) begin
      // Stopped channel: nothing in flight to protect, apply right away.
      div_d  = pdiv_q;
      cnt_d  = '0;
      pend_d = 1'b0;
    end

    // Writes are only offered while the slot is empty, so this never
    // collides with an apply on the same edge; a write landing on a terminal
    // count therefore waits for the following one.
    if (wr_i) begin
      pdiv_d = (wr_div_i == '0) ? CNT_W'(1) : wr_div_i;
      pend_d = 1'b1;
    end
  end

  // Channel state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= RST_DIV_V;
      pdiv_q <= RST_DIV_V;
      pend_q <= 1'b0;
      dclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      dclk_q <= dclk_d;
      tick_q <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign dclk_o = dclk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / tick generator.
// Divisor writes arrive over a valid/ready port and are applied per channel
// at that channel's next terminal count.
// Optional feature macro: CLK_DIV_SYNC_EN adds the 'sync' global restart input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [N_CH-1:0]  en,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [N_CH-1:0]  dclk,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;
  logic            sync_w;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Ready mux: a channel is busy while its pending slot is full; selects
  // that match no channel are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  // Channel-select decode of an accepted write.
  always_comb begin
    wr = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en[g]),
      .sync_i   (sync_w),
      .wr_i     (wr[g]),
      .wr_div_i (cfg_div),
      .pend_o   (pend[g]),
      .dclk_o   (dclk[g]),
      .tick_o   (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: randomized stimulus, reference model in
// terms of half-period lengths, monitor processes compare DUT outputs.
module tb_clk_div_bank;

  localparam int N   = 5;   // 5 channels -> 3-bit select, so 5..7 are out of range
  localparam int CW  = 16;
  localparam int DD  = 4;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [N-1:0]   en = '0;
  logic           sync = 1'b0;
  logic [N-1:0]   dclk, tick;

  always #5 clk = ~clk;

  clk_div_bank #(.N_CH(N), .CNT_W(CW), .DEFAULT_DIV(DD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .en        (en),
`ifdef CLK_DIV_SYNC_EN
    .sync      (sync),
`endif
    .dclk      (dclk),
    .tick      (tick)
  );

  typedef struct packed {
    logic [N-1:0] dclk;
    logic [N-1:0] tick;
  } out_t;

  out_t exp_q[$];
  bit   exp_rdy_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: elapsed edges in the current half-period, half-period
  // length, output level, and a one-entry pending slot.
  int m_elapsed[N];
  int m_half[N];
  bit m_lvl[N];
  int m_pdiv[N];
  bit m_has[N];

  function automatic void chk(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < N; c++) begin
      m_elapsed[c] = 0; m_half[c] = DD; m_lvl[c] = 0; m_pdiv[c] = DD; m_has[c] = 0;
    end
  endfunction

  function automatic bit m_ready(input int ch);
    if (ch >= N) return 1'b1;
    return !m_has[ch];
  endfunction

  // Advance the model by one clock edge with the given inputs.
  function automatic void m_step(input logic [N-1:0] en_v, input bit val,
                                 input int ch, input int dv, input bit sy);
    out_t e;
    bit   acc;
    acc = val && m_ready(ch);
    e = '0;
    for (int c = 0; c < N; c++) begin
      bit tk;
      tk = 0;
      if (sy) begin
        m_elapsed[c] = 0; m_lvl[c] = 0;
        if (m_has[c]) begin m_half[c] = m_pdiv[c]; m_has[c] = 0; end
      end else if (en_v[c]) begin
        m_elapsed[c]++;
        if (m_elapsed[c] >= m_half[c]) begin
          m_elapsed[c] = 0; m_lvl[c] = !m_lvl[c]; tk = 1;
          if (m_has[c]) begin m_half[c] = m_pdiv[c]; m_has[c] = 0; end
        end
      end else if (m_has[c]) begin
        m_half[c] = m_pdiv[c]; m_has[c] = 0; m_elapsed[c] = 0;
      end
      if (acc && ch == c) begin
        m_pdiv[c] = (dv == 0) ? 1 : dv;
        m_has[c]  = 1;
      end
      e.dclk[c] = m_lvl[c];
      e.tick[c] = tk;
    end
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of inputs (at posedge+3), record expectations, advance.
  task automatic drive(input logic [N-1:0] en_v, input bit val, input int ch,
                       input int dv, input bit sy);
    en = en_v; cfg_valid = val; cfg_ch = CHW'(ch); cfg_div = CW'(dv); sync = sy;
    exp_rdy_q.push_back(m_ready(ch));
    m_step(en_v, val, ch, dv, sy);
    @(posedge clk); #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_dclk", dclk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", cfg_ready, 1);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
  endtask

  // Output monitor: registered outputs after each edge.
  initial forever begin
    out_t e;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dclk", dclk, e.dclk);
      chk("tick", tick, e.tick);
    end
  end

  // Handshake monitor: combinational ready for the inputs of this cycle.
  initial forever begin
    @(negedge clk);
    if (exp_rdy_q.size() > 0) chk("cfg_ready", cfg_ready, exp_rdy_q.pop_front());
  end

  initial begin
    logic [N-1:0] en_r;
    bit sy;
    m_reset();
    #12;
    chk("init_dclk", dclk, 0);
    chk("init_tick", tick, 0);
    chk("init_ready", cfg_ready, 1);
    @(posedge clk); #3;
    rst = 1'b0;

    // Channel 0 alone on the default divisor.
    for (int i = 0; i < 12; i++) drive(5'b00001, 0, 0, 0, 0);
    // Stopped channel 1 takes div 3 on the next edge, then runs.
    drive(5'b00001, 1, 1, 3, 0);
    drive(5'b00001, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) drive(5'b00011, 0, 0, 0, 0);
    // Running ch0: write 2, then a second write that must stall.
    drive(5'b00011, 1, 0, 2, 0);
    for (int i = 0; i < 3; i++) drive(5'b00011, 1, 0, 5, 0);
    for (int i = 0; i < 10; i++) drive(5'b00011, 0, 0, 0, 0);
    // Divisor 0 becomes 1; out-of-range write is dropped.
    drive(5'b00111, 1, 2, 0, 0);
    drive(5'b00111, 1, 7, 2, 0);
    drive(5'b00111, 1, 5, 2, 0);
    for (int i = 0; i < 8; i++) drive(5'b00111, 0, 0, 0, 0);
    // Reset with a write still pending.
    drive(5'b00111, 1, 3, 6, 0);
    do_reset();
    for (int i = 0; i < 10; i++) drive(5'b11111, 0, 0, 0, 0);

    en_r = 5'b11111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en_r = N'($urandom);
      sy = 0;
`ifdef CLK_DIV_SYNC_EN
      sy = ($urandom_range(0, 49) == 0);
`endif
      if (i == 1000 || i == 2000) do_reset();
      drive(en_r, ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            $urandom_range(0, 6), sy);
    end
    cfg_valid = 0;
    @(posedge clk); #3;
    chk("out_queue_drained", exp_q.size(), 0);
    chk("rdy_queue_drained", exp_rdy_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
